// File: rtl/bit_scan_pkg.sv
// Shared types and default sizing for the bit scan sequencer.
// Optional early exit is selected by BIT_SCAN_EARLY_EXIT_EN (see bit_scan_sequencer).
package bit_scan_pkg;

    localparam int unsigned DefaultWidth   = 12;
    localparam int unsigned DefaultScanLen = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_idx_ctr.sv
// Scan index counter: cleared on scan start, advances once per checked bit,
// flags the last scanned index.
module scan_idx_ctr
    import bit_scan_pkg::*;
#(
    parameter int unsigned IdxW     = 4,
    parameter int unsigned SCAN_LEN = DefaultScanLen
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    output logic [IdxW-1:0] idx_o,
    output logic            last_o
);

    logic [IdxW-1:0] idx_q, idx_d;

    assign last_o = (idx_q == IdxW'(SCAN_LEN - 1));
    assign idx_o  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (en_i) begin
            idx_d = last_o ? '0 : idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/bit_scan_sequencer.sv
// Sequential bit-by-bit AND check of two captured operands with failure mask/count.
// Define BIT_SCAN_EARLY_EXIT_EN to stop the scan at the first failing bit.
module bit_scan_sequencer
    import bit_scan_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned SCAN_LEN = DefaultScanLen
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           foo,
    input  logic [WIDTH-1:0]           bar,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           fail_mask,
    output logic [$clog2(WIDTH+1)-1:0] fail_cnt,
    output logic                       first_fail_vld,
    output logic [$clog2(WIDTH)-1:0]   first_fail_idx
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    scan_state_e     state_q, state_d;
    logic [WIDTH-1:0] foo_q, foo_d, bar_q, bar_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ff_vld_q, ff_vld_d;
    logic [IdxW-1:0]  ff_idx_q, ff_idx_d;

    logic            ctr_clr, ctr_en, idx_last, bit_fail;
    logic [IdxW-1:0] idx;

    scan_idx_ctr #(
        .IdxW     (IdxW),
        .SCAN_LEN (SCAN_LEN)
    ) u_idx_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (ctr_clr),
        .en_i   (ctr_en),
        .idx_o  (idx),
        .last_o (idx_last)
    );

    always_comb begin
        state_d  = state_q;
        foo_d    = foo_q;
        bar_d    = bar_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        ff_vld_d = ff_vld_q;
        ff_idx_d = ff_idx_q;
        ctr_clr  = 1'b0;
        ctr_en   = 1'b0;
        bit_fail = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    foo_d    = foo;
                    bar_d    = bar;
                    mask_d   = '0;
                    cnt_d    = '0;
                    ff_vld_d = 1'b0;
                    ff_idx_d = '0;
                    ctr_clr  = 1'b1;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    ctr_en   = 1'b1;
                    bit_fail = ~(foo_q[idx] & bar_q[idx]);
                    if (bit_fail) begin
                        mask_d[idx] = 1'b1;
                        cnt_d       = cnt_q + CntW'(1);
                        if (!ff_vld_q) begin
                            ff_vld_d = 1'b1;
                            ff_idx_d = idx;
                        end
                    end
                    if (idx_last) begin
                        state_d = DONE;
                    end
`ifdef BIT_SCAN_EARLY_EXIT_EN
                    if (bit_fail) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            foo_q    <= '0;
            bar_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            ff_vld_q <= 1'b0;
            ff_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            foo_q    <= foo_d;
            bar_q    <= bar_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            ff_vld_q <= ff_vld_d;
            ff_idx_q <= ff_idx_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign fail_mask      = mask_q;
    assign fail_cnt       = cnt_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail_idx = ff_idx_q;

endmodule

// File: tb/tb_bit_scan_sequencer.sv
// Self-checking bench for bit_scan_sequencer: directed cases plus randomized scans
// compared against a per-bit loop model of the scan rules.
module tb_bit_scan_sequencer;

    localparam int W  = 12;
    localparam int SL = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [W-1:0]  foo, bar;
    logic          busy, done, first_fail_vld;
    logic [W-1:0]  fail_mask;
    logic [3:0]    fail_cnt;
    logic [3:0]    first_fail_idx;

    int n_cmp = 0;
    int n_mis = 0;

    bit_scan_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .foo            (foo),
        .bar            (bar),
        .busy           (busy),
        .done           (done),
        .fail_mask      (fail_mask),
        .fail_cnt       (fail_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scan rules: bits 0..SL-1 in order, abort cancels before its bit is checked,
    // optional stop after the first failure.
    task automatic model(input logic [W-1:0] f, input logic [W-1:0] b, input int abort_k,
                         output logic [W-1:0] m, output int cnt, output int ffi,
                         output bit ffv, output int nchk, output bit aborted);
        m = '0; cnt = 0; ffi = 0; ffv = 0; nchk = 0; aborted = 0;
        for (int i = 0; i < SL; i++) begin
            if (i == abort_k) begin
                aborted = 1;
                break;
            end
            nchk++;
            if (!(f[i] && b[i])) begin
                m[i] = 1'b1;
                cnt++;
                if (!ffv) begin
                    ffv = 1;
                    ffi = i;
                end
`ifdef BIT_SCAN_EARLY_EXIT_EN
                break;
`endif
            end
        end
    endtask

    task automatic check_results(input string pfx, input logic [W-1:0] m, input int cnt,
                                 input int ffi, input bit ffv);
        check_eq({pfx, "_mask"}, 32'(fail_mask), 32'(m));
        check_eq({pfx, "_cnt"}, 32'(fail_cnt), 32'(cnt));
        check_eq({pfx, "_ffvld"}, 32'(first_fail_vld), 32'(ffv));
        check_eq({pfx, "_ffidx"}, 32'(first_fail_idx), 32'(ffi));
    endtask

    // Called at a negedge; mut: 0 none, 1 foo<=0, 2 random change, all during SCAN.
    task automatic do_scan(input logic [W-1:0] f, input logic [W-1:0] b, input int abort_k,
                           input int mut);
        logic [W-1:0] m;
        int cnt, ffi, nchk, j, exp_j;
        bit ffv, aborted, seen_done;
        foo = f; bar = b; start = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        j = 1;
        seen_done = 0;
        while (j <= SL + 5) begin
            if (done) begin
                seen_done = 1;
                break;
            end
            if (!busy) break;
            abort = (j == abort_k + 1);
            start = (j == 2);
            if (j == 1 && mut == 1) foo = '0;
            if (j == 1 && mut == 2) begin
                foo = ~f;
                bar = W'($urandom);
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0; abort = 1'b0;
        model(f, b, abort_k, m, cnt, ffi, ffv, nchk, aborted);
        exp_j = aborted ? abort_k + 2 : nchk + 1;
        check_eq("exit_cycle", 32'(j), 32'(exp_j));
        check_eq("done_seen", 32'(seen_done), 32'(!aborted));
        if (seen_done) begin
            check_eq("busy_in_done", 32'(busy), 32'd1);
            check_results("done", m, cnt, ffi, ffv);
            @(negedge clk);
        end
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);
        check_results("end", m, cnt, ffi, ffv);
        foo = W'($urandom); bar = W'($urandom);
        @(negedge clk);
        check_results("hold", m, cnt, ffi, ffv);
    endtask

    initial begin
        logic [W-1:0] pm;
        int pc, pi;
        bit pv;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; foo = '0; bar = '0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_results("rst", '0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_scan(12'hFFF, 12'hFFF, -1, 0);
        do_scan(12'hFF0, 12'hF0F, -1, 0);
        do_scan(12'hFFF, 12'hFFF, -1, 1);
        do_scan(12'h000, 12'hFFF, 4, 0);
        do_scan(12'hFF7, 12'hFFF, -1, 0);

        // start with abort in IDLE must not start a scan
        pm = fail_mask; pc = int'(fail_cnt); pi = int'(first_fail_idx); pv = first_fail_vld;
        foo = 12'h000; bar = 12'h000; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_results("start_abort", pm, pc, pi, pv);

        // reset mid-scan clears everything without waiting for a clock edge
        foo = 12'h0F0; bar = 12'h0FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("amid_busy", 32'(busy), 32'd0);
        check_eq("amid_done", 32'(done), 32'd0);
        check_results("amid", '0, 0, 0, 0);
        @(negedge clk);
        check_eq("amid_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        do_scan(12'hABC, 12'h5F3, -1, 0);

        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] rf, rb;
            int ak;
            rf = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(3) == 0) begin
                rf = rf | W'($urandom);
                rb = rb | W'($urandom);
            end
            ak = ($urandom_range(3) == 0) ? int'($urandom_range(SL - 1)) : -1;
            do_scan(rf, rb, ak, int'($urandom_range(2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
